hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-stage hazard/forward logic.
- Replaces the per-stage destination compares with a per-register scoreboard that tracks every in-flight write and its remaining latency.
- Supports multi-cycle producers (loads, mul/div), NUM_SRC source operands and a global memory freeze.
- Sits beside the ID stage; drives the pipeline stall and per-source forward-hit flags registered into EXE.

Parameters:
- REG_LENGTH, 5, register-address width; NUM_REGS = 2**REG_LENGTH; register 0 is hard-wired zero.
- NUM_SRC, 3, source operands checked per instruction (src1, src2, store source).
- LAT_W, 3, width of latency counters; maximum producer latency is 2**LAT_W-1.
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk, input, 1, pipeline clock.
- rst, input, 1, synchronous active-high reset.
- forward_EN, input, 1, 1 = bypass network present; a result is usable when its counter reaches 0.
- issue_valid, input, 1, ID holds a valid instruction.
- src_addr, input, NUM_SRC*REG_LENGTH, source registers; operand k occupies bits [k*REG_LENGTH +: REG_LENGTH].
- src_valid, input, NUM_SRC, per-source "operand actually read" (already qualified by is_imm/store/branch).
- is_branch, input, 1, instruction resolves a branch in ID.
- dest_addr, input, REG_LENGTH, destination register.
- wb_en, input, 1, instruction writes dest_addr.
- issue_lat, input, LAT_W, cycles from issue until the result appears on the bypass bus (1 = ALU, 2 = load, larger = multi-cycle).
- is_load, input, 1, producer is a load.
- mem_stall, input, 1, memory not ready; freezes the whole pipeline.
- wb_valid, input, 1, a write retires to the register file this cycle.
- wb_dest, input, REG_LENGTH, register retired.
- stall, output, 1, hold IF/ID and bubble EXE.
- hazard_detected, output, 1, operand hazard only (excludes mem_stall).
- fwd_hit, output, NUM_SRC, registered; bit k = EXE operand k must take the bypass bus.
- stall_count, output, STALL_CNT_W, saturating count of cycles with stall = 1.

Behaviour:
- Per-register state: busy (1b), cnt (LAT_W), ld (1b). Register 0 is never busy.
- Reset (synchronous): all busy, cnt, ld = 0; fwd_hit = 0; stall_count = 0. stall and hazard_detected read 0 in the cycle after reset deasserts, provided issue_valid = 0. Reset mid-operation discards every pending entry.
- Per-source hazard h[k] = issue_valid & src_valid[k] & src != 0 & busy[src] & blk, where blk is:
  - forward_EN = 0: always 1; wait for retirement.
  - forward_EN = 1, non-branch: cnt[src] != 0.
  - forward_EN = 1, branch: (cnt[src] != 0) | ld[src]; a branch never consumes a load result off the bypass bus.
- hazard_detected = OR of h[k]. stall = hazard_detected | mem_stall. Both are combinational from current state and inputs; no added latency.
- Issue fires when issue_valid & ~stall.
  - If wb_en & dest != 0: busy[dest] <= 1, cnt[dest] <= issue_lat, ld[dest] <= is_load.
  - issue_lat = 0 is treated as 1.
- Countdown: each cycle with mem_stall = 0, every busy entry with cnt != 0 decrements by 1 (saturating at 0). With mem_stall = 1, all counters hold.
- Retire: wb_valid & wb_dest != 0 clears busy, cnt and ld of wb_dest.
- Simultaneous retire and issue to the same register: issue wins; the entry reloads.
- Issue and countdown on the same register in one cycle: the loaded value wins; no decrement that cycle.
- fwd_hit: on issue, fwd_hit[k] <= src_valid[k] & busy[src] & forward_EN & cnt[src] == 0. When stall = 1, fwd_hit <= 0 (bubble), except under mem_stall, where fwd_hit holds.
- stall_count increments on every cycle with stall = 1 and saturates at all ones.
- Architectural ordering of writes to the same register (WAW) is not checked here; the in-order pipeline guarantees it.

Test Plan:
- Reset, then ADD r3 (lat 1) followed by an instruction reading r3 with forward_EN = 1 -> stall = 0 on the second issue; fwd_hit[0] = 1 next cycle.
- Same sequence with forward_EN = 0 -> stall = 1 until wb_valid with wb_dest = 3; then stall = 0, fwd_hit = 0.
- Load r5 (lat 2, is_load) then a consumer of r5 -> exactly 1 stall cycle; stall_count = 1.
- Load r5 then a branch reading r5 -> stall held until r5 retires.
- Multi-cycle r7 (lat 5) with mem_stall pulsed 2 cycles mid-countdown -> consumer stalls 4 + 2 = 6 cycles; fwd_hit holds during mem_stall.
- Retire and reissue of r9 in the same cycle -> busy[9] stays 1 with cnt = new issue_lat; a read of r0 never stalls; rst asserted mid-countdown -> next-cycle stall = 0 and stall_count = 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard for ID-stage operand hazards. It tracks each in-flight write
// with its remaining latency and drives the pipeline stall and registered EXE forward-hit flags.
module hazard_scoreboard #(
    parameter int unsigned REG_LENGTH  = 5,
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned LAT_W       = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          forward_EN,
    input  logic                          issue_valid,
    input  logic [NUM_SRC*REG_LENGTH-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic                          is_branch,
    input  logic [REG_LENGTH-1:0]         dest_addr,
    input  logic                          wb_en,
    input  logic [LAT_W-1:0]              issue_lat,
    input  logic                          is_load,
    input  logic                          mem_stall,
    input  logic                          wb_valid,
    input  logic [REG_LENGTH-1:0]         wb_dest,
    output logic                          stall,
    output logic                          hazard_detected,
    output logic [NUM_SRC-1:0]            fwd_hit,
    output logic [STALL_CNT_W-1:0]        stall_count
);

    localparam int unsigned NUM_REGS = 2 ** REG_LENGTH;

    logic [NUM_REGS-1:0]    busy_q, busy_d;
    logic [NUM_REGS-1:0]    ld_q, ld_d;
    logic [LAT_W-1:0]       cnt_q [NUM_REGS];
    logic [LAT_W-1:0]       cnt_d [NUM_REGS];
    logic [NUM_SRC-1:0]     fwd_hit_q, fwd_hit_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic [NUM_SRC-1:0]     hazard_vec;
    logic [NUM_SRC-1:0]     fwd_vec;
    logic                   issue_fire;
    logic [LAT_W-1:0]       load_cnt;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_LENGTH-1:0] src;
        logic                  src_busy;
        logic                  src_ready;
        logic                  blk;

        assign src       = src_addr[k*REG_LENGTH +: REG_LENGTH];
        assign src_busy  = (src != '0) & busy_q[src];
        assign src_ready = (cnt_q[src] == '0);
        // A branch resolves in ID and cannot pick a load result off the bypass bus.
        assign blk = ~forward_EN | ~src_ready | (is_branch & ld_q[src]);
        assign hazard_vec[k] = issue_valid & src_valid[k] & src_busy & blk;
        assign fwd_vec[k]    = src_valid[k] & src_busy & forward_EN & src_ready;
    end

    assign hazard_detected = |hazard_vec;
    assign stall           = hazard_detected | mem_stall;
    assign issue_fire      = issue_valid & ~stall;
    assign fwd_hit         = fwd_hit_q;
    assign stall_count     = stall_count_q;

    // The counter holds the cycles still to wait once the producer has left ID, so the
    // issue cycle itself counts as the first one (an ALU result is ready for the next instruction).
    assign load_cnt = (issue_lat == '0) ? '0 : issue_lat - LAT_W'(1);

    always_comb begin
        busy_d = busy_q;
        ld_d   = ld_q;
        cnt_d  = cnt_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue_fire && wb_en && dest_addr == REG_LENGTH'(r)) begin
                busy_d[r] = 1'b1;
                cnt_d[r]  = load_cnt;
                ld_d[r]   = is_load;
            end else if (wb_valid && wb_dest == REG_LENGTH'(r)) begin
                busy_d[r] = 1'b0;
                cnt_d[r]  = '0;
                ld_d[r]   = 1'b0;
            end else if (!mem_stall && busy_q[r] && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
        busy_d[0] = 1'b0;
        ld_d[0]   = 1'b0;
        cnt_d[0]  = '0;
    end

    always_comb begin
        fwd_hit_d = '0;
        if (mem_stall) begin
            fwd_hit_d = fwd_hit_q;
        end else if (issue_fire) begin
            fwd_hit_d = fwd_vec;
        end
        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            ld_q          <= '0;
            cnt_q         <= '{default: '0};
            fwd_hit_q     <= '0;
            stall_count_q <= '0;
        end else begin
            busy_q        <= busy_d;
            ld_q          <= ld_d;
            cnt_q         <= cnt_d;
            fwd_hit_q     <= fwd_hit_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. It checks the stall timing, the forward flags and
// the stall counter with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        forward_EN;
    logic        issue_valid;
    logic [14:0] src_addr;
    logic [2:0]  src_valid;
    logic        is_branch;
    logic [4:0]  dest_addr;
    logic        wb_en;
    logic [2:0]  issue_lat;
    logic        is_load;
    logic        mem_stall;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        stall;
    logic        hazard_detected;
    logic [2:0]  fwd_hit;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .forward_EN     (forward_EN),
        .issue_valid    (issue_valid),
        .src_addr       (src_addr),
        .src_valid      (src_valid),
        .is_branch      (is_branch),
        .dest_addr      (dest_addr),
        .wb_en          (wb_en),
        .issue_lat      (issue_lat),
        .is_load        (is_load),
        .mem_stall      (mem_stall),
        .wb_valid       (wb_valid),
        .wb_dest        (wb_dest),
        .stall          (stall),
        .hazard_detected(hazard_detected),
        .fwd_hit        (fwd_hit),
        .stall_count    (stall_count)
    );

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task nextCycle();
        @(posedge clk);
        #1;
    endtask

    task applyStimulus(input logic iv, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [2:0] sv, input logic br, input logic [4:0] dst,
                       input logic we, input logic [2:0] lat, input logic ld);
        issue_valid = iv;
        src_addr    = {5'd0, s1, s0};
        src_valid   = sv;
        is_branch   = br;
        dest_addr   = dst;
        wb_en       = we;
        issue_lat   = lat;
        is_load     = ld;
        #1;
    endtask

    task resetDut();
        rst       = 1'b1;
        mem_stall = 1'b0;
        wb_valid  = 1'b0;
        wb_dest   = 5'd0;
        applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        nextCycle();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        forward_EN = 1'b1;
        resetDut();
        checkOutput("rst.stall", stall, 0);
        checkOutput("rst.hazard", hazard_detected, 0);
        checkOutput("rst.fwd_hit", fwd_hit, 0);
        checkOutput("rst.stall_count", stall_count, 0);

        // ALU producer r3 then consumer with bypass, then a mem_stall freeze
        applyStimulus(1, 0, 0, 3'b000, 0, 3, 1, 1, 0);
        checkOutput("A.prod_stall", stall, 0);
        nextCycle();
        applyStimulus(1, 3, 0, 3'b001, 0, 4, 1, 1, 0);
        checkOutput("A.cons_stall", stall, 0);
        checkOutput("A.cons_hazard", hazard_detected, 0);
        nextCycle();
        checkOutput("A.fwd_hit", fwd_hit, 3'b001);
        applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        mem_stall = 1'b1;
        #1;
        checkOutput("A.memstall_stall", stall, 1);
        checkOutput("A.memstall_hazard", hazard_detected, 0);
        nextCycle();
        checkOutput("A.fwd_hold", fwd_hit, 3'b001);
        checkOutput("A.stall_count", stall_count, 1);
        mem_stall = 1'b0;
        #1;
        nextCycle();
        checkOutput("A.fwd_idle", fwd_hit, 3'b000);

        // No bypass: consumer waits for retirement of r3
        resetDut();
        forward_EN = 1'b0;
        applyStimulus(1, 0, 0, 3'b000, 0, 3, 1, 1, 0);
        nextCycle();
        applyStimulus(1, 3, 0, 3'b001, 0, 0, 0, 1, 0);
        checkOutput("B.c1_stall", stall, 1);
        checkOutput("B.c1_hazard", hazard_detected, 1);
        nextCycle();
        checkOutput("B.c2_stall", stall, 1);
        checkOutput("B.c2_fwd", fwd_hit, 3'b000);
        nextCycle();
        wb_valid = 1'b1;
        wb_dest  = 5'd3;
        #1;
        checkOutput("B.wb_stall", stall, 1);
        nextCycle();
        wb_valid = 1'b0;
        #1;
        checkOutput("B.after_wb_stall", stall, 0);
        checkOutput("B.stall_count", stall_count, 3);
        nextCycle();
        checkOutput("B.fwd_hit", fwd_hit, 3'b000);

        // Load r5 then ALU consumer: one bubble
        resetDut();
        forward_EN = 1'b1;
        applyStimulus(1, 0, 0, 3'b000, 0, 5, 1, 2, 1);
        nextCycle();
        applyStimulus(1, 5, 0, 3'b001, 0, 6, 1, 1, 0);
        checkOutput("C.c1_stall", stall, 1);
        nextCycle();
        checkOutput("C.c2_stall", stall, 0);
        nextCycle();
        checkOutput("C.fwd_hit", fwd_hit, 3'b001);
        checkOutput("C.stall_count", stall_count, 1);

        // Load r5 then branch: held until r5 retires
        resetDut();
        applyStimulus(1, 0, 0, 3'b000, 0, 5, 1, 2, 1);
        nextCycle();
        applyStimulus(1, 5, 0, 3'b001, 1, 0, 0, 1, 0);
        checkOutput("D.c1_stall", stall, 1);
        nextCycle();
        checkOutput("D.c2_stall", stall, 1);
        checkOutput("D.c2_hazard", hazard_detected, 1);
        nextCycle();
        wb_valid = 1'b1;
        wb_dest  = 5'd5;
        #1;
        checkOutput("D.wb_stall", stall, 1);
        nextCycle();
        wb_valid = 1'b0;
        #1;
        checkOutput("D.after_wb_stall", stall, 0);
        checkOutput("D.stall_count", stall_count, 3);
        nextCycle();
        checkOutput("D.fwd_hit", fwd_hit, 3'b000);

        // Multi-cycle r7 (lat 5) with a two-cycle memory freeze mid-countdown
        resetDut();
        applyStimulus(1, 0, 0, 3'b000, 0, 7, 1, 5, 0);
        nextCycle();
        applyStimulus(1, 7, 0, 3'b001, 0, 0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            mem_stall = (i == 2 || i == 3);
            #1;
            if (!stall) break;
            n++;
            nextCycle();
        end
        mem_stall = 1'b0;
        checkOutput("E.stall_cycles", n, 6);
        checkOutput("E.stall_count", stall_count, 6);
        nextCycle();
        checkOutput("E.fwd_hit", fwd_hit, 3'b001);

        // Retire and reissue r9 in one cycle, r0 reads, reset mid-countdown
        resetDut();
        applyStimulus(1, 0, 0, 3'b000, 0, 9, 1, 3, 0);
        nextCycle();
        applyStimulus(1, 0, 0, 3'b000, 0, 9, 1, 4, 0);
        wb_valid = 1'b1;
        wb_dest  = 5'd9;
        #1;
        checkOutput("F.reissue_stall", stall, 0);
        nextCycle();
        wb_valid = 1'b0;
        applyStimulus(1, 0, 0, 3'b011, 0, 0, 1, 1, 0);
        checkOutput("F.r0_stall", stall, 0);
        applyStimulus(1, 9, 0, 3'b001, 0, 0, 0, 1, 0);
        checkOutput("F.c1_stall", stall, 1);
        nextCycle();
        nextCycle();
        checkOutput("F.c3_stall", stall, 1);
        checkOutput("F.c3_stall_count", stall_count, 2);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("F.post_rst_stall", stall, 0);
        checkOutput("F.post_rst_count", stall_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
